// File: rtl/mm_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the register-bus decoder.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface mm_bus_arbiter_if #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TO_CNT_W = 16
);
  logic              a_req;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rdata_v;

  logic              b_req;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rdata_v;

  logic [ADDR_W-1:0] mm_addr;
  logic              mm_wr_en;
  logic              mm_rd_en;
  logic [DATA_W-1:0] mm_wr_data;
  logic [DATA_W-1:0] mm_rd_data;
  logic              mm_rd_data_v;

  logic [TO_CNT_W-1:0] to_cnt;
  logic                to_cnt_clr;
  logic                stray_err;

  modport master (
    input  a_req, a_wr, a_addr, a_wdata,
    output a_ack, a_rdata, a_rdata_v,
    input  b_req, b_wr, b_addr, b_wdata,
    output b_ack, b_rdata, b_rdata_v,
    output mm_addr, mm_wr_en, mm_rd_en, mm_wr_data,
    input  mm_rd_data, mm_rd_data_v,
    output to_cnt, stray_err,
    input  to_cnt_clr
  );

  modport slave (
    output a_req, a_wr, a_addr, a_wdata,
    input  a_ack, a_rdata, a_rdata_v,
    output b_req, b_wr, b_addr, b_wdata,
    input  b_ack, b_rdata, b_rdata_v,
    input  mm_addr, mm_wr_en, mm_rd_en, mm_wr_data,
    output mm_rd_data, mm_rd_data_v,
    input  to_cnt, stray_err,
    output to_cnt_clr
  );
endinterface

// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing the memory-mapped register bus between requesters A and B,
// one transaction outstanding, with a read timeout that forces completion.
module mm_bus_arbiter #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned TO_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  mm_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE_GAP,
    S_RD_WAIT,
    S_RD_RET
  } state_e;

  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                last_b_q, last_b_d;
  logic                owner_b_q, owner_b_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [ADDR_W-1:0]   mm_addr_q, mm_addr_d;
  logic [DATA_W-1:0]   mm_wdata_q, mm_wdata_d;
  logic                mm_wr_en_q, mm_wr_en_d;
  logic                mm_rd_en_q, mm_rd_en_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                a_rdv_q, a_rdv_d;
  logic                b_rdv_q, b_rdv_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                stray_q, stray_d;

  logic                grant_a;
  logic                grant_b;
  logic                win_wr;
  logic                to_inc;
  logic [DATA_W-1:0]   ret_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_b_q   <= 1'b1;
      owner_b_q  <= 1'b0;
      timer_q    <= '0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      mm_wr_en_q <= 1'b0;
      mm_rd_en_q <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rdv_q    <= 1'b0;
      b_rdv_q    <= 1'b0;
      to_cnt_q   <= '0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      owner_b_q  <= owner_b_d;
      timer_q    <= timer_d;
      mm_addr_q  <= mm_addr_d;
      mm_wdata_q <= mm_wdata_d;
      mm_wr_en_q <= mm_wr_en_d;
      mm_rd_en_q <= mm_rd_en_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rdv_q    <= a_rdv_d;
      b_rdv_q    <= b_rdv_d;
      to_cnt_q   <= to_cnt_d;
      stray_q    <= stray_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    owner_b_d  = owner_b_q;
    timer_d    = timer_q;
    mm_addr_d  = mm_addr_q;
    mm_wdata_d = mm_wdata_q;
    mm_wr_en_d = 1'b0;
    mm_rd_en_d = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rdv_d    = 1'b0;
    b_rdv_d    = 1'b0;
    to_cnt_d   = to_cnt_q;
    stray_d    = stray_q;
    to_inc     = 1'b0;

    grant_a = bus.a_req && (!bus.b_req || last_b_q);
    grant_b = bus.b_req && !grant_a;
    win_wr  = grant_b ? bus.b_wr : bus.a_wr;

    ret_word                       = '0;
    ret_word[ADDR_W-1:0]           = mm_addr_q;
    ret_word[DATA_W-1 -: 16]       = 16'hDEAD;

    unique case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          last_b_d   = grant_b;
          owner_b_d  = grant_b;
          mm_addr_d  = grant_b ? bus.b_addr  : bus.a_addr;
          mm_wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
          a_ack_d    = grant_a;
          b_ack_d    = grant_b;
          if (win_wr) begin
            mm_wr_en_d = 1'b1;
            state_d    = S_ISSUE_GAP;
          end else begin
            mm_rd_en_d = 1'b1;
            timer_d    = '0;
            state_d    = S_RD_WAIT;
          end
        end
      end
      S_ISSUE_GAP: state_d = S_IDLE;
      S_RD_WAIT: begin
        // The timer stays at 0 through the issue cycle itself, so forced completion
        // lands TIMEOUT+1 cycles after mm_rd_en rather than TIMEOUT.
        if (!mm_rd_en_q) begin
          timer_d = timer_q + TMR_W'(1);
        end
        if (bus.mm_rd_data_v) begin
          if (owner_b_q) b_rdata_d = bus.mm_rd_data;
          else           a_rdata_d = bus.mm_rd_data;
          a_rdv_d = !owner_b_q;
          b_rdv_d = owner_b_q;
          state_d = S_RD_RET;
        end else if (timer_q == TMR_LAST) begin
          if (owner_b_q) b_rdata_d = ret_word;
          else           a_rdata_d = ret_word;
          a_rdv_d = !owner_b_q;
          b_rdv_d = owner_b_q;
          to_inc  = 1'b1;
          state_d = S_RD_RET;
        end
      end
      S_RD_RET: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (bus.mm_rd_data_v && (state_q != S_RD_WAIT)) begin
      stray_d = 1'b1;
    end

    if (bus.to_cnt_clr) begin
      to_cnt_d = '0;
      stray_d  = 1'b0;
    end else if (to_inc && (to_cnt_q != '1)) begin
      to_cnt_d = to_cnt_q + TO_CNT_W'(1);
    end
  end

  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.a_rdata_v  = a_rdv_q;
  assign bus.b_rdata_v  = b_rdv_q;
  assign bus.mm_addr    = mm_addr_q;
  assign bus.mm_wr_data = mm_wdata_q;
  assign bus.mm_wr_en   = mm_wr_en_q;
  assign bus.mm_rd_en   = mm_rd_en_q;
  assign bus.to_cnt     = to_cnt_q;
  assign bus.stray_err  = stray_q;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: transaction-level reference model compared every cycle,
// plus hand-computed expectations for each scenario.
module tb_mm_bus_arbiter;
  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned TO_CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  always #5 clk = ~clk;

  mm_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CNT_W(TO_CNT_W)) bus ();

  mm_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_CNT_W(TO_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bus is free, busy for one gap cycle, or waiting on a read with an age.
  bit              m_pend, m_own_b, m_last_b, m_was_wait, m_inc, m_pick_b, m_wr;
  int              m_age, m_gap;
  logic [16:0]     m_addr;
  logic [63:0]     m_wdata, m_ardata, m_brdata, m_val;
  bit              m_aack, m_back, m_ardv, m_brdv, m_wren, m_rden, m_stray;
  logic [15:0]     m_tocnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0; m_own_b = 0; m_last_b = 1; m_age = 0; m_gap = 0;
      m_addr = '0; m_wdata = '0; m_ardata = '0; m_brdata = '0;
      m_aack = 0; m_back = 0; m_ardv = 0; m_brdv = 0; m_wren = 0; m_rden = 0;
      m_stray = 0; m_tocnt = '0;
    end else begin
      m_was_wait = m_pend;
      m_inc = 0;
      m_aack = 0; m_back = 0; m_ardv = 0; m_brdv = 0; m_wren = 0; m_rden = 0;
      if (m_pend) begin
        m_age++;
        if (bus.mm_rd_data_v || m_age == TIMEOUT + 1) begin
          m_val = bus.mm_rd_data_v ? bus.mm_rd_data : {32'hDEAD_0000, 15'h0, m_addr};
          m_inc = !bus.mm_rd_data_v;
          if (m_own_b) begin m_brdata = m_val; m_brdv = 1; end
          else         begin m_ardata = m_val; m_ardv = 1; end
          m_pend = 0;
          m_gap  = 1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (bus.a_req || bus.b_req) begin
        m_pick_b = bus.b_req && (!bus.a_req || !m_last_b);
        m_last_b = m_pick_b;
        m_own_b  = m_pick_b;
        m_addr   = m_pick_b ? bus.b_addr  : bus.a_addr;
        m_wdata  = m_pick_b ? bus.b_wdata : bus.a_wdata;
        m_wr     = m_pick_b ? bus.b_wr    : bus.a_wr;
        m_aack   = !m_pick_b;
        m_back   = m_pick_b;
        if (m_wr) begin m_wren = 1; m_gap = 1; end
        else      begin m_rden = 1; m_pend = 1; m_age = 0; end
      end
      if (bus.mm_rd_data_v && !m_was_wait) m_stray = 1;
      if (bus.to_cnt_clr) begin m_tocnt = '0; m_stray = 0; end
      else if (m_inc && m_tocnt != 16'hFFFF) m_tocnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_a_ack",     64'(bus.a_ack),      64'(m_aack));
      chk("m_b_ack",     64'(bus.b_ack),      64'(m_back));
      chk("m_a_rdata_v", 64'(bus.a_rdata_v),  64'(m_ardv));
      chk("m_b_rdata_v", 64'(bus.b_rdata_v),  64'(m_brdv));
      chk("m_a_rdata",   bus.a_rdata,         m_ardata);
      chk("m_b_rdata",   bus.b_rdata,         m_brdata);
      chk("m_wr_en",     64'(bus.mm_wr_en),   64'(m_wren));
      chk("m_rd_en",     64'(bus.mm_rd_en),   64'(m_rden));
      chk("m_addr",      64'(bus.mm_addr),    64'(m_addr));
      chk("m_wr_data",   bus.mm_wr_data,      m_wdata);
      chk("m_to_cnt",    64'(bus.to_cnt),     64'(m_tocnt));
      chk("m_stray",     64'(bus.stray_err),  64'(m_stray));
      chk("m_en_excl",   64'(bus.mm_wr_en && bus.mm_rd_en), 64'(0));
    end
  end

  // Raise a request and hold it until its ack is seen; returns on the ack cycle.
  task automatic issue(input bit is_b, input bit wr, input logic [16:0] addr,
                       input logic [63:0] data);
    bit got;
    got = 0;
    if (is_b) begin bus.b_req = 1; bus.b_wr = wr; bus.b_addr = addr; bus.b_wdata = data; end
    else      begin bus.a_req = 1; bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = data; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_b ? bus.b_ack : bus.a_ack;
    end
    if (!got) begin failures++; $display("FAIL ack_timeout actual=0 required=1"); end
    if (is_b) bus.b_req = 0; else bus.a_req = 0;
  endtask

  int n, na, nb, seen;
  int wr_t[$];
  string order;

  initial begin
    bus.a_req = 0; bus.a_wr = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_wr = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.mm_rd_data = '0; bus.mm_rd_data_v = 0; bus.to_cnt_clr = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    cmp_en = 1;
    @(negedge clk);
    chk("rst_wr_en",  64'(bus.mm_wr_en), 0);
    chk("rst_addr",   64'(bus.mm_addr),  0);
    chk("rst_to_cnt", 64'(bus.to_cnt),   0);
    chk("rst_stray",  64'(bus.stray_err), 0);

    // A write
    issue(0, 1, 17'h00010, 64'h1122334455667788);
    chk("wr_en",    64'(bus.mm_wr_en),   1);
    chk("wr_addr",  64'(bus.mm_addr),    64'h10);
    chk("wr_data",  bus.mm_wr_data,      64'h1122334455667788);
    chk("wr_b_ack", 64'(bus.b_ack),      0);
    @(negedge clk);
    chk("wr_en_off", 64'(bus.mm_wr_en),  0);
    @(negedge clk);

    // B read, decoder answers three cycles later
    issue(1, 0, 17'h08004, '0);
    chk("rd_en",   64'(bus.mm_rd_en), 1);
    chk("rd_addr", 64'(bus.mm_addr),  64'h08004);
    repeat (3) @(negedge clk);
    bus.mm_rd_data = 64'hCAFEF00D12345678; bus.mm_rd_data_v = 1;
    @(negedge clk);
    bus.mm_rd_data_v = 0;
    chk("b_rdv",   64'(bus.b_rdata_v), 1);
    chk("b_rdata", bus.b_rdata,        64'hCAFEF00D12345678);
    chk("b_a_rdv", 64'(bus.a_rdata_v), 0);
    @(negedge clk);
    chk("b_rdv_pulse", 64'(bus.b_rdata_v), 0);

    // Both requesting writes: alternate grants
    bus.a_wr = 1; bus.a_addr = 17'h00100; bus.a_wdata = 64'hA;
    bus.b_wr = 1; bus.b_addr = 17'h00200; bus.b_wdata = 64'hB;
    bus.a_req = 1; bus.b_req = 1;
    na = 0; nb = 0; order = "";
    for (int c = 0; c < 30 && (na + nb) < 4; c++) begin
      @(negedge clk);
      if (bus.mm_wr_en) wr_t.push_back(c);
      if (bus.a_ack) begin order = {order, "A"}; na++; if (na == 2) bus.a_req = 0; end
      if (bus.b_ack) begin order = {order, "B"}; nb++; if (nb == 2) bus.b_req = 0; end
    end
    bus.a_req = 0; bus.b_req = 0;
    chk("rr_order", (order == "ABAB") ? 64'd1 : 64'd0, 1);
    chk("rr_count", 64'(wr_t.size()), 4);
    if (wr_t.size() == 4)
      for (int i = 1; i < 4; i++) chk("rr_spacing", 64'(wr_t[i] - wr_t[i-1]), 2);
    @(negedge clk);

    // A read with no data: timeout
    issue(0, 0, 17'h1FFFF, '0);
    n = 0; seen = 0;
    while (n < 200 && !seen) begin @(negedge clk); n++; seen = bus.a_rdata_v; end
    chk("to_latency", 64'(n), 65);
    chk("to_rdata",   bus.a_rdata, 64'hDEAD0000_0001FFFF);
    chk("to_cnt1",    64'(bus.to_cnt), 1);
    @(negedge clk);

    // Stray valid in idle, then clear
    bus.mm_rd_data = 64'h5555; bus.mm_rd_data_v = 1;
    @(negedge clk);
    bus.mm_rd_data_v = 0;
    chk("stray_set",   64'(bus.stray_err), 1);
    chk("stray_a_rdv", 64'(bus.a_rdata_v), 0);
    chk("stray_b_rdv", 64'(bus.b_rdata_v), 0);
    bus.to_cnt_clr = 1;
    @(negedge clk);
    bus.to_cnt_clr = 0;
    chk("clr_stray",  64'(bus.stray_err), 0);
    chk("clr_to_cnt", 64'(bus.to_cnt),    0);

    // Data valid on the very timeout edge: real data wins, no count
    issue(0, 0, 17'h00ABC, '0);
    repeat (64) @(negedge clk);
    bus.mm_rd_data = 64'h0123456789ABCDEF; bus.mm_rd_data_v = 1;
    @(negedge clk);
    bus.mm_rd_data_v = 0;
    chk("tie_rdv",    64'(bus.a_rdata_v), 1);
    chk("tie_rdata",  bus.a_rdata,        64'h0123456789ABCDEF);
    chk("tie_to_cnt", 64'(bus.to_cnt),    0);
    @(negedge clk);

    // Clear coinciding with a timeout increment
    issue(1, 0, 17'h00042, '0);
    repeat (64) @(negedge clk);
    bus.to_cnt_clr = 1;
    @(negedge clk);
    bus.to_cnt_clr = 0;
    chk("clrpri_rdv",    64'(bus.b_rdata_v), 1);
    chk("clrpri_rdata",  bus.b_rdata,        64'hDEAD0000_00000042);
    chk("clrpri_to_cnt", 64'(bus.to_cnt),    0);
    @(negedge clk);

    // Reset during a read, late valid afterwards
    issue(0, 0, 17'h00777, '0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus.mm_rd_data = 64'h9999; bus.mm_rd_data_v = 1;
    @(negedge clk);
    bus.mm_rd_data_v = 0;
    chk("rstrd_stray", 64'(bus.stray_err), 1);
    chk("rstrd_a_rdv", 64'(bus.a_rdata_v), 0);
    chk("rstrd_rdata", bus.a_rdata,        0);
    @(negedge clk);
    chk("rstrd_a_rdv2", 64'(bus.a_rdata_v), 0);
    issue(0, 1, 17'h00003, 64'h33);
    chk("rstrd_wr_en", 64'(bus.mm_wr_en), 1);
    chk("rstrd_addr",  64'(bus.mm_addr),  3);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
